vga_scan_gen: RTL
=================

VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
- Parameters, one per line: name, default, meaning.
- Ports, one per line: name, direction, width, meaning.

REQ-001 H_ACTIVE, 640, visible pixels per line.
REQ-002 H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels; line total H_TOT = 800.
REQ-003 V_ACTIVE, 480, visible lines per frame.
REQ-004 V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines; frame total V_TOT = 525.
REQ-005 SYNC_POL, 0, sync active level (0 = active-low).
REQ-006 CLK_50MHZ  in  1  system clock; the only clock in the block.
REQ-007 RST_n  in  1  asynchronous, active-low reset.
REQ-008 PIX_DATA  in  18  pixel as {R[5:0], G[5:0], B[5:0]}.
REQ-009 PIX_VALID  in  1  PIX_DATA holds a valid pixel.
REQ-010 PIX_READY  out  1  the block takes a pixel this clock.
REQ-011 UNDERFLOW_CLR  in  1  clears UNDERFLOW.
REQ-012 VGA_R / VGA_G / VGA_B  out  6 each  registered pixel colour.
REQ-013 VGA_HSYNC / VGA_VSYNC  out  1 each  registered sync outputs.
REQ-014 BLANK  out  1  high when the registered outputs are outside the active area.
REQ-015 FRAME_START  out  1  one-clock pulse at the start of each frame.
REQ-016 UNDERFLOW  out  1  sticky flag: a pixel was missing during the active area.

Function
REQ-017 Internal pixel enable ce SHALL toggle every clock, giving a 25 MHz pixel rate; ce = 0 in the first clock after reset release.
REQ-018 hcnt (10 bits) SHALL increment on ce clocks and wrap from H_TOT-1 to 0; on that wrap, vcnt (10 bits) SHALL increment, wrapping from V_TOT-1 to 0.
REQ-019 Active area SHALL be hcnt < H_ACTIVE and vcnt < V_ACTIVE.
REQ-020 hsync region SHALL be H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
REQ-021 vsync region SHALL be V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
REQ-022 PIX_READY SHALL be combinational: ce AND active area; it is asserted exactly 640 clocks per active line and never during blanking.
REQ-023 A transfer SHALL occur when PIX_READY and PIX_VALID are both high; PIX_VALID without PIX_READY SHALL be ignored, with no buffering.
REQ-024 On each ce clock, the outputs SHALL register state for the current (hcnt, vcnt):
  - VGA_R/G/B = PIX_DATA fields on a transfer, otherwise 0;
  - BLANK = NOT active;
  - syncs = SYNC_POL inside their region, else ~SYNC_POL.
  Outputs SHALL hold across the non-ce clock.
REQ-025 Latency: a pixel accepted at clock t SHALL appear on VGA_R/G/B from t+1 for exactly 2 clocks, aligned with its BLANK and sync values.
REQ-026 If PIX_READY is high and PIX_VALID is low, that pixel SHALL output 0 and UNDERFLOW SHALL be set; the counters SHALL never stall.
REQ-027 If UNDERFLOW_CLR and a new underflow occur in the same clock, set SHALL win; otherwise UNDERFLOW_CLR SHALL clear the flag on the next clock.
REQ-028 FRAME_START SHALL pulse for one clock on the ce clock where hcnt = 0 and vcnt = 0, aligned with that pixel's registered outputs.
REQ-029 RGB fields SHALL pass through unscaled at 6 bits; any colour or monochrome mapping belongs downstream.

Reset
REQ-030 RST_n low SHALL immediately force:
  - hcnt = 0, vcnt = 0, ce = 0;
  - VGA_R/G/B = 0, BLANK = 1;
  - VGA_HSYNC = VGA_VSYNC = ~SYNC_POL;
  - FRAME_START = 0, UNDERFLOW = 0.
REQ-031 Reset asserted mid-line or mid-frame SHALL abort the frame; after release, scanning SHALL restart at (0, 0) with the first FRAME_START on the second clock.

Verification
REQ-032 Hold PIX_VALID = 1 for 2 frames -> exactly 800*525*2 = 840000 clocks between FRAME_START pulses, 307200 transfers per frame, UNDERFLOW = 0.
REQ-033 Measure syncs with SYNC_POL = 0 -> VGA_HSYNC low for 192 clocks per 1600-clock line, starting 1312 clocks after line start; VGA_VSYNC low for 2 lines starting at line 490.
REQ-034 Feed PIX_DATA = 18'h3F000 on the first transfer -> VGA_R = 6'h3F, VGA_G = 0, VGA_B = 0 on the next 2 clocks with BLANK = 0; RGB = 0 while BLANK = 1.
REQ-035 Drop PIX_VALID for one active pixel at (10, 5) -> that pixel outputs 0 and UNDERFLOW rises; pulse UNDERFLOW_CLR during blanking -> UNDERFLOW = 0 next clock; clear coincident with a new underflow -> UNDERFLOW stays 1.
REQ-036 Assert RST_n low at hcnt = 400, vcnt = 200 -> all outputs at reset values within the same clock; after release, FRAME_START on the second clock and normal timing resumes.

Source files
------------

// File: rtl/vga_scan_gen_if.sv
// Pixel stream handshake between a pixel source and the VGA scan generator.
// The source drives data/valid; the scan generator answers with ready.
interface vga_scan_gen_if;
    logic [17:0] pix_data;   // {R[5:0], G[5:0], B[5:0]}
    logic        pix_valid;
    logic        pix_ready;

    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA scan generator: derives a half-rate pixel enable from the system clock,
// walks the line/frame counters, pulls pixels over a ready/valid stream and
// registers colour, blank and sync outputs. Missing pixels are flagged sticky.
module vga_scan_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    vga_scan_gen_if.slave pix,
    input  logic       underflow_clr,
    output logic [5:0] vga_r,
    output logic [5:0] vga_g,
    output logic [5:0] vga_b,
    output logic       vga_hsync,
    output logic       vga_vsync,
    output logic       blank,
    output logic       frame_start,
    output logic       underflow
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
    localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       ce;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       active;
    logic       hs_region;
    logic       vs_region;
    logic       xfer;
    logic       starve;

    assign active    = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
    assign hs_region = (hcnt >= HS_BEGIN) && (hcnt < HS_END);
    assign vs_region = (vcnt >= VS_BEGIN) && (vcnt < VS_END);

    // Ready only on the pixel-enable clock of a visible pixel; never stalls.
    assign pix.pix_ready = ce & active;
    assign xfer          = pix.pix_ready & pix.pix_valid;
    assign starve        = pix.pix_ready & ~pix.pix_valid;

    // Pixel enable toggles every clock; counters advance on enabled clocks.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            ce   <= 1'b0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            ce <= ~ce;
            if (ce) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    // Register colour/blank/sync for the current position; hold on non-enable clocks.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
            blank     <= 1'b1;
            vga_hsync <= ~SYNC_POL;
            vga_vsync <= ~SYNC_POL;
        end else if (ce) begin
            vga_r     <= xfer ? pix.pix_data[17:12] : 6'd0;
            vga_g     <= xfer ? pix.pix_data[11:6]  : 6'd0;
            vga_b     <= xfer ? pix.pix_data[5:0]   : 6'd0;
            blank     <= ~active;
            vga_hsync <= hs_region ? SYNC_POL : ~SYNC_POL;
            vga_vsync <= vs_region ? SYNC_POL : ~SYNC_POL;
        end
    end

    // Frame start is a single-clock pulse, aligned with the first pixel's outputs.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= ce && (hcnt == '0) && (vcnt == '0);
        end
    end

    // Sticky underflow; a new starve event takes priority over a clear.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (starve) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule
